lsu_mem_responder: RTL and testbench

//  Data-memory responder on the LSU side bus. Accepts word-aligned accesses with byte-lane strobes from
//  the combinational LSU; performs byte-masked writes and full-word reads on an internal word array.

---
 rtl/lsu_mem_responder.sv | 115 +++++++++++
 tb/tb_lsu_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_responder.sv
// LSU-side data memory responder: byte-masked writes, full-word reads, and a one-cycle
// ack/err pulse after a fixed number of wait states.
module lsu_mem_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_dat_i,
    input  logic [3:0]  lsu_sel_i,
    input  logic        lsu_we_i,
    input  logic        lsu_re_i,
    output logic [31:0] lsu_dat_o,
    output logic        lsu_ack_o,
    output logic        lsu_err_o,
    output logic        busy_o
);

    localparam int unsigned IdxW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] MemBytes = 32'(MEM_WORDS * 4);
    localparam logic [3:0]  CntInit  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q, dat_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic [31:0] dat_out_q;
    logic        ack_q, err_q, busy_q;

    logic [31:0] mem [MEM_WORDS];

    logic        req;
    logic [31:0] cur_addr, cur_dat, off;
    logic [3:0]  cur_sel;
    logic        cur_we, bad, go_resp;
    logic [IdxW-1:0] idx;

    // With zero wait states the access completes straight from IDLE, so decode uses live inputs.
    always_comb begin
        req      = lsu_we_i | lsu_re_i;
        cur_addr = (state_q == StIdle) ? lsu_addr_i : addr_q;
        cur_dat  = (state_q == StIdle) ? lsu_dat_i  : dat_q;
        cur_sel  = (state_q == StIdle) ? lsu_sel_i  : sel_q;
        cur_we   = (state_q == StIdle) ? lsu_we_i   : we_q;
        off      = cur_addr - BASE_ADDR;
        bad      = (off >= MemBytes) || (cur_addr[1:0] != 2'b00);
        idx      = off[IdxW+1:2];
        go_resp  = ((state_q == StIdle) && req && (WAIT_CYCLES == 0)) ||
                   ((state_q == StWait) && (cnt_q == 4'd0));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            dat_out_q <= 32'd0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q <= lsu_addr_i;
                        dat_q  <= lsu_dat_i;
                        sel_q  <= lsu_sel_i;
                        we_q   <= lsu_we_i;
                        if (WAIT_CYCLES != 0) begin
                            state_q <= StWait;
                            cnt_q   <= CntInit;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                end
                StResp: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
            if (go_resp) begin
                state_q <= StResp;
                busy_q  <= 1'b1;
                ack_q   <= ~bad;
                err_q   <= bad;
                if (!bad && !cur_we) dat_out_q <= mem[idx];
            end
        end
    end

    // Memory is deliberately not reset; a reset in the commit cycle discards the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && go_resp && cur_we && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_sel[b]) mem[idx][8*b +: 8] <= cur_dat[8*b +: 8];
            end
        end
    end

    assign lsu_dat_o = dat_out_q;
    assign lsu_ack_o = ack_q;
    assign lsu_err_o = err_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder: three instances (1, 0 and 15 wait states) share the
// request inputs; each test task checks the instance it targets.
module tb_lsu_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = 32'd0, dat = 32'd0;
    logic [3:0]  sel = 4'd0;
    logic        we = 1'b0, re = 1'b0;

    logic [31:0] dat1, dat0, dat15;
    logic        ack1, ack0, ack15, err1, err0, err15, busy1, busy0, busy15;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_w1 (
        .clk_i(clk), .rst_i(rst), .lsu_addr_i(addr), .lsu_dat_i(dat), .lsu_sel_i(sel),
        .lsu_we_i(we), .lsu_re_i(re), .lsu_dat_o(dat1), .lsu_ack_o(ack1), .lsu_err_o(err1),
        .busy_o(busy1)
    );
    lsu_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h1000), .WAIT_CYCLES(0)) u_w0 (
        .clk_i(clk), .rst_i(rst), .lsu_addr_i(addr), .lsu_dat_i(dat), .lsu_sel_i(sel),
        .lsu_we_i(we), .lsu_re_i(re), .lsu_dat_o(dat0), .lsu_ack_o(ack0), .lsu_err_o(err0),
        .busy_o(busy0)
    );
    lsu_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(15)) u_w15 (
        .clk_i(clk), .rst_i(rst), .lsu_addr_i(addr), .lsu_dat_i(dat), .lsu_sel_i(sel),
        .lsu_we_i(we), .lsu_re_i(re), .lsu_dat_o(dat15), .lsu_ack_o(ack15), .lsu_err_o(err15),
        .busy_o(busy15)
    );

    // which: 0 -> 1 wait state, 1 -> 0 wait states, 2 -> 15 wait states
    task automatic peek(input int which, output logic a, output logic e, output logic [31:0] d);
        case (which)
            0:       begin a = ack1;  e = err1;  d = dat1;  end
            1:       begin a = ack0;  e = err0;  d = dat0;  end
            default: begin a = ack15; e = err15; d = dat15; end
        endcase
    endtask

    // Drive one access, hold until ack/err (bounded), drop it, then idle one cycle.
    // lat counts rising edges from capture to the response becoming visible; -1 on timeout.
    task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int which, input bit toggle,
                          output int lat, output logic ack_seen, output logic err_seen,
                          output logic [31:0] rdata, output logic ack_after);
        logic pa, pe;
        logic [31:0] pd;
        int i;
        @(negedge clk);
        we = w; re = r; addr = a; dat = d; sel = s;
        lat = -1; ack_seen = 1'b0; err_seen = 1'b0; rdata = 32'hx; i = 0;
        while (lat < 0 && i < 40) begin
            @(posedge clk); #1;
            i++;
            if (toggle && i == 1) addr = a ^ 32'h4;
            peek(which, pa, pe, pd);
            if (pa || pe) begin
                lat = i; ack_seen = pa; err_seen = pe; rdata = pd;
            end
        end
        we = 1'b0; re = 1'b0;
        @(posedge clk); #1;
        peek(which, ack_after, pe, pd);
    endtask

    int          lat;
    logic        ka, ke, kafter;
    logic [31:0] kd;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ack1, err1, busy1, dat1} !== 35'd0) begin
            failures++;
            $display("FAIL reset_w1 got ack=%b err=%b busy=%b dat=%h exp 0", ack1, err1, busy1, dat1);
        end
        checks++;
        if ({ack0, err0, busy0, dat0, ack15, err15, busy15, dat15} !== 70'd0) begin
            failures++;
            $display("FAIL reset_w0_w15 got busy0=%b busy15=%b dat0=%h dat15=%h exp 0",
                     busy0, busy15, dat0, dat15);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        access(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (lat !== 2 || ka !== 1'b1 || ke !== 1'b0) begin
            failures++;
            $display("FAIL wr_latency got lat=%0d ack=%b err=%b exp lat=2 ack=1 err=0", lat, ka, ke);
        end
        checks++;
        if (kafter !== 1'b0) begin
            failures++;
            $display("FAIL ack_one_cycle got ack_next=%b exp 0", kafter);
        end
        access(0, 1, 32'h10, 32'h0, 4'hF, 0, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (lat !== 2 || ka !== 1'b1 || kd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_0x10 got lat=%0d ack=%b dat=%h exp lat=2 ack=1 dat=deadbeef",
                     lat, ka, kd);
        end
    endtask

    task automatic test_byte_lanes();
        access(1, 0, 32'h20, 32'h11223344, 4'hF, 0, 0, lat, ka, ke, kd, kafter);
        access(1, 0, 32'h20, 32'hAAAAAAAA, 4'b0100, 0, 0, lat, ka, ke, kd, kafter);
        access(0, 1, 32'h20, 32'h0, 4'h0, 0, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (kd !== 32'h11AA3344 || ka !== 1'b1) begin
            failures++;
            $display("FAIL lane_merge got dat=%h ack=%b exp 11aa3344 ack=1", kd, ka);
        end
        access(1, 0, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (ka !== 1'b1 || ke !== 1'b0) begin
            failures++;
            $display("FAIL sel0_ack got ack=%b err=%b exp ack=1 err=0", ka, ke);
        end
        access(0, 1, 32'h20, 32'h0, 4'hF, 0, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (kd !== 32'h11AA3344) begin
            failures++;
            $display("FAIL sel0_nochange got dat=%h exp 11aa3344", kd);
        end
    endtask

    task automatic test_errors();
        access(1, 0, 32'h0, 32'hCAFEF00D, 4'hF, 0, 0, lat, ka, ke, kd, kafter);
        access(0, 1, 32'h10, 32'h0, 4'hF, 0, 0, lat, ka, ke, kd, kafter);
        access(0, 1, 32'h1002, 32'h0, 4'hF, 0, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (ke !== 1'b1 || ka !== 1'b0 || lat !== 2) begin
            failures++;
            $display("FAIL rd_err_0x1002 got err=%b ack=%b lat=%0d exp err=1 ack=0 lat=2", ke, ka, lat);
        end
        access(0, 1, 32'h12, 32'h0, 4'hF, 0, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (ke !== 1'b1 || ka !== 1'b0) begin
            failures++;
            $display("FAIL rd_misaligned got err=%b ack=%b exp err=1 ack=0", ke, ka);
        end
        access(1, 0, 32'h1000, 32'h12345678, 4'hF, 0, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (ke !== 1'b1 || ka !== 1'b0 || kd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_err_0x1000 got err=%b ack=%b dat=%h exp err=1 ack=0 dat=deadbeef",
                     ke, ka, kd);
        end
        // 0x1000 would alias word 0 if the range check leaked into the array index.
        access(0, 1, 32'h0, 32'h0, 4'hF, 0, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (kd !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL no_alias_write got dat=%h exp cafef00d", kd);
        end
    endtask

    task automatic test_wait_states();
        repeat (20) @(posedge clk);
        access(1, 0, 32'h1008, 32'h600DF00D, 4'hF, 1, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (lat !== 1 || ka !== 1'b1) begin
            failures++;
            $display("FAIL w0_wr_latency got lat=%0d ack=%b exp lat=1 ack=1", lat, ka);
        end
        access(0, 1, 32'h1008, 32'h0, 4'hF, 1, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (lat !== 1 || kd !== 32'h600DF00D) begin
            failures++;
            $display("FAIL w0_rd got lat=%0d dat=%h exp lat=1 dat=600df00d", lat, kd);
        end
        access(0, 1, 32'h0FFC, 32'h0, 4'hF, 1, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (ke !== 1'b1 || ka !== 1'b0) begin
            failures++;
            $display("FAIL below_base got err=%b ack=%b exp err=1 ack=0", ke, ka);
        end
        repeat (20) @(posedge clk);
        access(1, 0, 32'h50, 32'hA5A5A5A5, 4'hF, 2, 0, lat, ka, ke, kd, kafter);
        access(1, 0, 32'h54, 32'h5A5A5A5A, 4'hF, 2, 0, lat, ka, ke, kd, kafter);
        access(0, 1, 32'h50, 32'h0, 4'hF, 2, 1, lat, ka, ke, kd, kafter);
        checks++;
        if (lat !== 16 || ka !== 1'b1) begin
            failures++;
            $display("FAIL w15_latency got lat=%0d ack=%b exp lat=16 ack=1", lat, ka);
        end
        checks++;
        if (kd !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL w15_captured_addr got dat=%h exp a5a5a5a5", kd);
        end
    endtask

    task automatic test_both_we_re();
        access(1, 1, 32'h30, 32'h5, 4'hF, 0, 0, lat, ka, ke, kd, kafter);
        access(0, 1, 32'h30, 32'h0, 4'hF, 0, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (kd !== 32'h00000005) begin
            failures++;
            $display("FAIL we_priority got dat=%h exp 00000005", kd);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] seen;
        repeat (20) @(posedge clk);
        @(negedge clk);
        re = 1'b1; addr = 32'h10; sel = 4'hF;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            seen[i] = ack1;
        end
        re = 1'b0;
        @(posedge clk);
        checks++;
        if (seen !== 9'b010_010_010) begin
            failures++;
            $display("FAIL back_to_back got ack_pattern=%b exp 010010010", seen);
        end
    endtask

    task automatic test_reset_mid();
        logic any_ack;
        repeat (20) @(posedge clk);
        access(1, 0, 32'h40, 32'h0, 4'hF, 2, 0, lat, ka, ke, kd, kafter);
        @(negedge clk);
        we = 1'b1; addr = 32'h40; dat = 32'hFFFFFFFF; sel = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy15 !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_wait got busy=%b exp 1", busy15);
        end
        @(negedge clk);
        rst = 1'b1; we = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy15 !== 1'b0 || ack15 !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_reset got busy=%b ack=%b exp 0 0", busy15, ack15);
        end
        @(negedge clk);
        rst = 1'b0;
        any_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            any_ack = any_ack | ack15;
        end
        checks++;
        if (any_ack !== 1'b0) begin
            failures++;
            $display("FAIL no_ack_after_abort got ack_seen=%b exp 0", any_ack);
        end
        access(0, 1, 32'h40, 32'h0, 4'hF, 2, 0, lat, ka, ke, kd, kafter);
        checks++;
        if (kd !== 32'h0 || ka !== 1'b1) begin
            failures++;
            $display("FAIL write_discarded got dat=%h ack=%b exp 00000000 ack=1", kd, ka);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_errors();
        test_wait_states();
        test_both_we_re();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
